// File: rtl/nv_dfcn_pipe.sv
// WIDTH-bit, DEPTH-stage valid/ready retiming pipeline built from async-clear flops.
// Supports bubble collapse or lock-step stalling, synchronous flush and an occupancy count.
module nv_dfcn_pipe #(
    parameter int               WIDTH           = 8,
    parameter int               DEPTH           = 4,
    parameter logic [WIDTH-1:0] RST_VAL         = {WIDTH{1'b0}},
    parameter int               BUBBLE_COLLAPSE = 1
) (
    input  logic                         CP,
    input  logic                         CDN,
    input  logic                         in_vld,
    output logic                         in_rdy,
    input  logic [WIDTH-1:0]             in_pd,
    output logic                         out_vld,
    input  logic                         out_rdy,
    output logic [WIDTH-1:0]             out_pd,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);

    localparam int OCCW = $clog2(DEPTH + 1);

    if (WIDTH < 1 || DEPTH < 1) begin : gBadParam
        $error("nv_dfcn_pipe: WIDTH and DEPTH must both be at least 1");
    end

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] pd_q [DEPTH];
    logic [WIDTH-1:0] pd_d [DEPTH];
    logic [OCCW-1:0]  occ_q;
    logic [OCCW-1:0]  occ_d;

    logic [DEPTH-1:0] acc;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] upVld;
    logic [WIDTH-1:0] upPd [DEPTH];
    logic             advance;
    logic             inXfer;

    // acc[i] is set when some stage at or after i can make room this cycle;
    // without collapse every stage follows the single output-side advance.
    always_comb begin
        advance = ~vld_q[DEPTH-1] | out_rdy;
        acc = '0;
        acc[DEPTH-1] = advance;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            acc[i] = ~vld_q[i] | acc[i+1];
        end
        load = (BUBBLE_COLLAPSE != 0) ? acc : {DEPTH{advance}};

        in_rdy = load[0] & ~flush;
        inXfer = in_vld & in_rdy;

        upVld    = '0;
        upVld[0] = inXfer;
        upPd[0]  = in_pd;
        for (int i = 1; i < DEPTH; i++) begin
            upVld[i] = vld_q[i-1];
            upPd[i]  = pd_q[i-1];
        end

        // Payloads only move with a valid beat, so an emptied stage keeps its
        // last value and flush leaves every payload where it was.
        vld_d = vld_q;
        pd_d  = pd_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (load[i]) begin
                vld_d[i] = upVld[i];
                if (upVld[i] && !flush) begin
                    pd_d[i] = upPd[i];
                end
            end
        end
        if (flush) begin
            vld_d = '0;
        end

        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCCW'(vld_d[i]);
        end
    end

    always_ff @(posedge CP or negedge CDN) begin
        if (!CDN) begin
            vld_q <= '0;
            occ_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pd_q[i] <= RST_VAL;
            end
        end else begin
            vld_q <= vld_d;
            pd_q  <= pd_d;
            occ_q <= occ_d;
        end
    end

    assign out_vld = vld_q[DEPTH-1];
    assign out_pd  = pd_q[DEPTH-1];
    assign occ     = occ_q;

endmodule

// File: tb/tb_nv_dfcn_pipe.sv
// Bench for nv_dfcn_pipe: four instances (collapse / lock-step, depths 1, 4 and 7) share stimulus
// and are compared every cycle against a slot-list reference model.
module tb_nv_dfcn_pipe;

    logic       clock;
    logic       resetN;
    logic       inVld;
    logic [7:0] inPd;
    logic       outRdy;
    logic       flushIn;

    logic       rdyA, rdyB, rdyC, rdyD;
    logic       vldA, vldB, vldC, vldD;
    logic [7:0] pdA, pdB, pdC, pdD;
    logic [2:0] occA, occB, occD;
    logic [0:0] occC;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: each pipe is a list of slots, index depth-1 being the output slot.
    int         mDepth [4] = '{4, 4, 1, 7};
    int         mMode  [4] = '{1, 0, 1, 0};
    logic [7:0] mRst   [4] = '{8'hA5, 8'h3C, 8'h00, 8'h5A};
    bit         mVld   [4][8];
    logic [7:0] mPd    [4][8];
    logic [7:0] mLast  [4];

    nv_dfcn_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5), .BUBBLE_COLLAPSE(1)) dutA (
        .CP(clock), .CDN(resetN), .in_vld(inVld), .in_rdy(rdyA), .in_pd(inPd),
        .out_vld(vldA), .out_rdy(outRdy), .out_pd(pdA), .flush(flushIn), .occ(occA));

    nv_dfcn_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'h3C), .BUBBLE_COLLAPSE(0)) dutB (
        .CP(clock), .CDN(resetN), .in_vld(inVld), .in_rdy(rdyB), .in_pd(inPd),
        .out_vld(vldB), .out_rdy(outRdy), .out_pd(pdB), .flush(flushIn), .occ(occB));

    nv_dfcn_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h00), .BUBBLE_COLLAPSE(1)) dutC (
        .CP(clock), .CDN(resetN), .in_vld(inVld), .in_rdy(rdyC), .in_pd(inPd),
        .out_vld(vldC), .out_rdy(outRdy), .out_pd(pdC), .flush(flushIn), .occ(occC));

    nv_dfcn_pipe #(.WIDTH(8), .DEPTH(7), .RST_VAL(8'h5A), .BUBBLE_COLLAPSE(0)) dutD (
        .CP(clock), .CDN(resetN), .in_vld(inVld), .in_rdy(rdyD), .in_pd(inPd),
        .out_vld(vldD), .out_rdy(outRdy), .out_pd(pdD), .flush(flushIn), .occ(occD));

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Single comparison point: counts every check and reports any difference.
    task automatic checkOutput(input string tag, input int k, input logic [31:0] obs,
                               input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s dut%0d at %0t: got 0x%0h, expected 0x%0h", tag, k, $time, obs, exp);
        end
    endtask

    // Selects one observed output of instance k: 0 in_rdy, 1 out_vld, 2 out_pd, 3 occ.
    function automatic logic [31:0] obsField(input int k, input int f);
        logic [31:0] r;
        r = '0;
        case (k)
            0: case (f) 0: r = 32'(rdyA); 1: r = 32'(vldA); 2: r = 32'(pdA); default: r = 32'(occA); endcase
            1: case (f) 0: r = 32'(rdyB); 1: r = 32'(vldB); 2: r = 32'(pdB); default: r = 32'(occB); endcase
            2: case (f) 0: r = 32'(rdyC); 1: r = 32'(vldC); 2: r = 32'(pdC); default: r = 32'(occC); endcase
            default: case (f) 0: r = 32'(rdyD); 1: r = 32'(vldD); 2: r = 32'(pdD); default: r = 32'(occD); endcase
        endcase
        return r;
    endfunction

    function automatic int modelOcc(input int k);
        int n = 0;
        for (int j = 0; j < mDepth[k]; j++) n += int'(mVld[k][j]);
        return n;
    endfunction

    // Index of the slot that disappears this cycle (delivered/empty output slot, or with
    // collapse the last bubble), or -1 when nothing can move.
    function automatic int modelFreeSlot(input int k, input bit ordy);
        int d   = mDepth[k];
        int idx = -1;
        if (!mVld[k][d-1] || ordy) begin
            idx = d - 1;
        end else if (mMode[k] == 1) begin
            for (int j = 0; j < d; j++) if (!mVld[k][j]) idx = j;
        end
        return idx;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                mVld[k][j] = 1'b0;
                mPd[k][j]  = 8'h00;
            end
            mLast[k] = mRst[k];
        end
    endtask

    task automatic modelStep(input int k, input bit iv, input logic [7:0] ip, input bit ordy,
                             input bit fl);
        int d   = mDepth[k];
        int idx = modelFreeSlot(k, ordy);
        if (fl) begin
            for (int j = 0; j < d; j++) mVld[k][j] = 1'b0;
        end else if (idx >= 0) begin
            for (int j = idx; j > 0; j--) begin
                mVld[k][j] = mVld[k][j-1];
                mPd[k][j]  = mPd[k][j-1];
            end
            mVld[k][0] = iv;
            mPd[k][0]  = ip;
        end
        if (mVld[k][d-1]) mLast[k] = mPd[k][d-1];
    endtask

    task automatic checkState(input bit withRdy);
        for (int k = 0; k < 4; k++) begin
            checkOutput("out_vld", k, obsField(k, 1), 32'(mVld[k][mDepth[k]-1]));
            checkOutput("out_pd", k, obsField(k, 2), 32'(mLast[k]));
            checkOutput("occ", k, obsField(k, 3), 32'(modelOcc(k)));
            if (withRdy)
                checkOutput("in_rdy", k, obsField(k, 0),
                            32'((modelFreeSlot(k, outRdy) >= 0) && !flushIn));
        end
    endtask

    // Drives one cycle of inputs at the falling edge, checks all instances, advances the model.
    task automatic applyStimulus(input bit iv, input logic [7:0] ip, input bit ordy, input bit fl);
        @(negedge clock);
        inVld   = iv;
        inPd    = ip;
        outRdy  = ordy;
        flushIn = fl;
        #1;
        checkState(1'b1);
        for (int k = 0; k < 4; k++) modelStep(k, iv, ip, ordy, fl);
    endtask

    // Asserts CDN mid-cycle, checks the asynchronous clear, then releases away from an edge.
    task automatic resetPulse();
        @(negedge clock);
        inVld   = 1'b0;
        outRdy  = 1'b0;
        flushIn = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        modelReset();
        checkOutput("rst_pd", 0, 32'(pdA), 32'h0000_00A5);
        checkOutput("rst_vld", 0, 32'(vldA), 32'd0);
        checkOutput("rst_occ", 0, 32'(occA), 32'd0);
        checkState(1'b0);
        @(posedge clock);
        @(negedge clock);
        #2;
        resetN = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        int         drained;
        logic [7:0] expA [4];
        bit         bpVld [6];
        logic [7:0] bpPd  [6];

        resetN  = 1'b0;
        inVld   = 1'b0;
        inPd    = 8'h00;
        outRdy  = 1'b0;
        flushIn = 1'b0;
        modelReset();
        resetPulse();

        // Streaming 0x01..0x08: beat k shows at out_pd on the observation k+3 cycles later.
        for (int n = 0; n < 12; n++) begin
            applyStimulus(n < 8, 8'(n + 1), 1'b1, 1'b0);
            checkOutput("stream_vld", 0, 32'(vldA), 32'(n >= 4));
            if (n >= 4) checkOutput("stream_pd", 0, 32'(pdA), 32'(n - 3));
        end
        idle(10);

        // Backpressure with a one-cycle bubble: collapse compacts, lock-step keeps the bubble.
        bpVld = '{1, 0, 1, 1, 1, 1};
        bpPd  = '{8'h10, 8'h00, 8'h11, 8'h12, 8'h13, 8'h14};
        for (int c = 0; c < 6; c++) begin
            applyStimulus(bpVld[c], bpPd[c], 1'b0, 1'b0);
            if (c == 4) begin
                checkOutput("bp_rdy", 0, 32'(rdyA), 32'd1);
                checkOutput("bp_rdy", 1, 32'(rdyB), 32'd0);
                checkOutput("bp_occ", 1, 32'(occB), 32'd3);
            end
            if (c == 5) begin
                checkOutput("bp_occ", 0, 32'(occA), 32'd4);
                checkOutput("bp_rdy", 0, 32'(rdyA), 32'd0);
            end
        end
        expA    = '{8'h10, 8'h11, 8'h12, 8'h13};
        drained = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            if (vldA && drained < 4) begin
                checkOutput("drain_pd", 0, 32'(pdA), 32'(expA[drained]));
                drained++;
            end
        end
        checkOutput("drain_cnt", 0, 32'(drained), 32'd4);

        // Flush at occupancy 3 with a beat offered: nothing accepted, everything dropped.
        applyStimulus(1'b1, 8'h20, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b1);
        checkOutput("flush_rdy", 0, 32'(rdyA), 32'd0);
        checkOutput("flush_occ_pre", 0, 32'(occA), 32'd3);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("flush_vld", 0, 32'(vldA), 32'd0);
            checkOutput("flush_occ", 0, 32'(occA), 32'd0);
        end

        // Full pipe with out_rdy=1 passes a beat through every cycle.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
            checkOutput("pass_rdy", 0, 32'(rdyA), 32'd1);
            checkOutput("pass_occ", 0, 32'(occA), 32'd4);
            checkOutput("pass_pd", 0, 32'(pdA), (i < 4) ? 32'(8'h30 + i) : 32'(8'h40 + i - 4));
        end

        // Clear while full, then randomised traffic including occasional flushes.
        resetPulse();
        for (int i = 0; i < 10000; i++) begin
            applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) < 6,
                          $urandom_range(0, 31) == 0);
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/nv_dfcn_pipe.md
Name: nv_dfcn_pipe

Overview:
- Parametrised successor to the single-bit async-clear D flip-flop cell: a WIDTH-bit, DEPTH-stage valid/ready retiming pipeline built from async-clear flops.
- Used on long datapath and control routes between NVDLA partitions, where multi-cycle retiming with backpressure replaces hand-chained flops.
- Adds per-stage valid, backpressure with optional bubble collapse, synchronous flush and an occupancy count. None of these exist in the single flop.

Parameters:
- WIDTH, 8, payload width in bits (>=1).
- DEPTH, 4, number of register stages (>=1).
- RST_VAL, {WIDTH{1'b0}}, payload value loaded on async clear.
- BUBBLE_COLLAPSE, 1. 1 = each stage advances independently and empty stages are filled while downstream stalls. 0 = whole pipe stalls together when output is stalled.

Ports:
- CP  in  1  clock, rising edge.
- CDN  in  1  asynchronous active-low clear.
- in_vld  in  1  upstream valid.
- in_rdy  out  1  upstream ready (combinational).
- in_pd  in  WIDTH  upstream payload.
- out_vld  out  1  valid of final stage (registered).
- out_rdy  in  1  downstream ready.
- out_pd  out  WIDTH  payload of final stage (registered).
- flush  in  1  synchronous discard of all stage contents.
- occ  out  $clog2(DEPTH+1)  count of valid stages (registered).

Behaviour:
- Interface: one clock CP; reset CDN is asynchronous, active-low.
- While CDN=0: all stage valids = 0, all stage payloads = RST_VAL, out_vld=0, out_pd=RST_VAL, occ=0.
- Recovery: first capture on the first CP rising edge after CDN deasserts.
- Stages 0..DEPTH-1. Stage DEPTH-1 drives out_vld/out_pd directly; there is no output combinational logic.
- Transfer rules: output transfer = out_vld & out_rdy; input transfer = in_vld & in_rdy.
- BUBBLE_COLLAPSE=1:
  - acc[DEPTH-1] = ~vld[DEPTH-1] | out_rdy.
  - acc[i] = ~vld[i] | acc[i+1].
  - in_rdy = acc[0] & ~flush.
  - Stage i loads from stage i-1 (or from the input for i=0) when acc[i].
  - On load, vld[i] takes the upstream valid. pd[i] updates only when the upstream valid is 1; otherwise pd holds.
- BUBBLE_COLLAPSE=0:
  - Global advance = ~out_vld | out_rdy. All stages shift only on advance.
  - in_rdy = advance & ~flush.
- Payload of a stage with vld=1 that is not loading is held stable. No data is ever duplicated or lost without flush.
- Latency: with out_rdy held 1, a beat accepted at edge N appears at out_vld on edge N+DEPTH-1 (first register = stage 0). Throughput is 1 beat/cycle.
- Flush:
  - At the next edge all vld clear to 0 and payloads hold.
  - in_rdy=0 during flush, so no beat is accepted that cycle.
  - An output transfer in the flush cycle still counts as delivered.
  - occ becomes 0 at the next edge.
- occ: next value = number of stage valids after the edge. It is always equal to the popcount of the stage valids; occ <= DEPTH.
- Full with out_rdy=0: in_rdy=0 in both modes.
- Full with out_rdy=1: in_rdy=1 (pass-through in the same cycle); occ stays DEPTH.
- Empty: out_vld=0 and out_pd keeps its last value (RST_VAL after reset).
- CDN asserting mid-stream discards all contents immediately, independent of CP.
- Undefined: DEPTH=0 or WIDTH=0 (elaboration assertion).

Test Plan:
- Reset/streaming (WIDTH=8, DEPTH=4, RST_VAL=8'hA5):
  - Pulse CDN low mid-cycle -> out_pd=8'hA5, out_vld=0, occ=0 asynchronously.
  - Release CDN; stream 0x01..0x08 with out_rdy=1 -> 0x01 on out_pd 3 edges after its accept; one beat per cycle after that.
- Backpressure, collapse (BUBBLE_COLLAPSE=1):
  - Insert beats 0x10,_,0x11 (one-cycle bubble); hold out_rdy=0 -> pipe compacts to occ=4 after 4 accepts, in_rdy=0.
  - Release out_rdy -> output order 0x10,0x11,.. with no loss.
- Backpressure, no collapse (BUBBLE_COLLAPSE=0):
  - Same stimulus -> bubble is preserved; in_rdy=0 whenever out_vld=1 and out_rdy=0.
  - occ never exceeds the number of beats accepted minus beats delivered.
- Flush: occ=3; assert flush with in_vld=1, in_pd=0x55 -> in_rdy=0, next edge occ=0, out_vld=0, and 0x55 never appears.
- Full pass-through: occ=4, out_rdy=1, in_vld=1 for 10 cycles -> in_rdy=1 every cycle, occ stays 4, all 10 beats delivered in order.
- Randomised scoreboard: DEPTH=1 and DEPTH=7, random in_vld/out_rdy/flush over 10k cycles -> output sequence equals input sequence minus flushed beats; occ matches the valid popcount every cycle.
